// File: rtl/dm_uart_mmio.sv
// Purpose : data-side memory for the single-cycle core: word RAM, 8N1 UART transmitter, cycle counter.
// Latency : loads are combinational in the same cycle; stores/register writes land on the next rising edge.
// Backpr. : none towards the core; a TXDATA write while a frame is in flight is dropped and latches overflow.
// Ports   : clk_DM/rst_DM (async active-low) clock and reset; ALU_Out_DM byte address;
//           writeData_DM/MemWrite_DM store data and strobe; RD_DM load data;
//           tx_DM serial line (idle high); tx_busy_DM frame in flight.
module dm_uart_mmio #(
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk_DM,
  input  logic        rst_DM,
  input  logic [31:0] ALU_Out_DM,
  input  logic [31:0] writeData_DM,
  input  logic        MemWrite_DM,
  output logic [31:0] RD_DM,
  output logic        tx_DM,
  output logic        tx_busy_DM
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // Word addresses (byte address >> 2) of the I/O registers.
  localparam logic [29:0] TXDATA_W = 30'h3FFF_C000;
  localparam logic [29:0] STATUS_W = 30'h3FFF_C001;
  localparam logic [29:0] CYCLES_W = 30'h3FFF_C002;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // ---------------------------------------------------------------- decode
  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          ram_hit, tx_sel, st_sel, cyc_sel;
  logic          tx_wr, st_wr, cyc_wr;
  logic          unused_addr_lsb;

  assign word_addr       = ALU_Out_DM[31:2];
  assign ram_idx         = word_addr[AW-1:0];
  assign ram_hit         = (word_addr[29:AW] == '0);
  assign tx_sel          = (word_addr == TXDATA_W);
  assign st_sel          = (word_addr == STATUS_W);
  assign cyc_sel         = (word_addr == CYCLES_W);
  assign tx_wr           = MemWrite_DM && tx_sel;
  assign st_wr           = MemWrite_DM && st_sel;
  assign cyc_wr          = MemWrite_DM && cyc_sel;
  assign unused_addr_lsb = ^ALU_Out_DM[1:0];

  // ---------------------------------------------------------------- RAM
  // Deliberately not reset: contents are undefined until software writes them.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_DM) begin
    if (MemWrite_DM && ram_hit) begin
      mem_q[ram_idx] <= writeData_DM;
    end
  end

  // ---------------------------------------------------------------- state
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          baud_last, tx_accept;

  assign baud_last = (baud_q == BAUD_LAST);
  // The last cycle of the stop bit can already accept the next byte, so
  // back-to-back frames need no idle cycle between them.
  assign tx_accept = (state_q == IDLE) || ((state_q == STOP) && baud_last);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_wr) begin
      if (tx_accept) begin
        state_d = START;
        baud_d  = '0;
        bit_d   = '0;
        shreg_d = writeData_DM[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Clear is applied last so it wins over any set.
    if (st_wr && writeData_DM[1]) begin
      ovf_d = 1'b0;
    end

    cyc_d = cyc_wr ? writeData_DM : (cyc_q + 32'd1);
  end

  always_ff @(posedge clk_DM or negedge rst_DM) begin
    if (!rst_DM) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // tx is a pure decode of reset flops, so an async reset forces it high at once.
  always_comb begin
    tx_DM = 1'b1;
    case (state_q)
      START:   tx_DM = 1'b0;
      DATA:    tx_DM = shreg_q[bit_q];
      default: tx_DM = 1'b1;
    endcase
  end

  assign tx_busy_DM = (state_q != IDLE);

  always_comb begin
    RD_DM = '0;
    if (ram_hit) begin
      RD_DM = mem_q[ram_idx];
    end else if (st_sel) begin
      RD_DM = {30'b0, ovf_q, tx_busy_DM};
    end else if (cyc_sel) begin
      RD_DM = cyc_q;
    end
  end

endmodule

// File: tb/tb_dm_uart_mmio.sv
module tb_dm_uart_mmio;

  localparam int DEPTH = 64;
  localparam int C     = 4;
  localparam logic [31:0] A_TX    = 32'hFFFF_0000;
  localparam logic [31:0] A_ST    = 32'hFFFF_0004;
  localparam logic [31:0] A_CY    = 32'hFFFF_0008;
  localparam logic [31:0] RAM_TOP = DEPTH * 4;

  logic        clk_DM = 1'b0;
  logic        rst_DM;
  logic [31:0] ALU_Out_DM;
  logic [31:0] writeData_DM;
  logic        MemWrite_DM;
  logic [31:0] RD_DM;
  logic        tx_DM;
  logic        tx_busy_DM;

  dm_uart_mmio #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk_DM      (clk_DM),
    .rst_DM      (rst_DM),
    .ALU_Out_DM  (ALU_Out_DM),
    .writeData_DM(writeData_DM),
    .MemWrite_DM (MemWrite_DM),
    .RD_DM       (RD_DM),
    .tx_DM       (tx_DM),
    .tx_busy_DM  (tx_busy_DM)
  );

  always #5 clk_DM = ~clk_DM;

  int errs   = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // A frame is described only by the edge it started on and its byte; the
  // line level follows from elapsed edges divided by the bit period.
  int          e_cnt  = 0;
  int          fstart = 0;
  bit          fvalid = 1'b0;
  logic [7:0]  fbyte  = '0;
  bit          ovf_m  = 1'b0;
  logic [31:0] cnt_m  = '0;
  logic [31:0] ram_m [DEPTH];
  bit          ram_v [DEPTH];

  always @(posedge clk_DM or negedge rst_DM) begin
    logic [31:0] a;
    if (!rst_DM) begin
      e_cnt  = 0;
      fvalid = 1'b0;
      ovf_m  = 1'b0;
      cnt_m  = '0;
      for (int i = 0; i < DEPTH; i++) ram_v[i] = 1'b0;
    end else begin
      e_cnt++;
      a = {ALU_Out_DM[31:2], 2'b00};
      if (MemWrite_DM) begin
        if (a < RAM_TOP) begin
          ram_m[a / 4] = writeData_DM;
          ram_v[a / 4] = 1'b1;
        end else if (a == A_TX) begin
          if (!fvalid || (e_cnt - fstart) >= 10 * C) begin
            fvalid = 1'b1;
            fstart = e_cnt;
            fbyte  = writeData_DM[7:0];
          end else begin
            ovf_m = 1'b1;
          end
        end else if (a == A_ST && writeData_DM[1]) begin
          ovf_m = 1'b0;
        end
      end
      if (MemWrite_DM && a == A_CY) cnt_m = writeData_DM;
      else cnt_m = cnt_m + 32'd1;
    end
  end

  function automatic logic exp_busy();
    return fvalid && ((e_cnt - fstart) < 10 * C);
  endfunction

  function automatic logic exp_tx();
    int slot;
    if (!exp_busy()) return 1'b1;
    slot = (e_cnt - fstart) / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return fbyte[slot - 1];
  endfunction

  function automatic logic rd_known();
    logic [31:0] a;
    a = {ALU_Out_DM[31:2], 2'b00};
    if (a < RAM_TOP) return ram_v[a / 4];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] a;
    a = {ALU_Out_DM[31:2], 2'b00};
    if (a < RAM_TOP) return ram_m[a / 4];
    if (a == A_TX)   return 32'h0;
    if (a == A_ST)   return {30'b0, ovf_m, exp_busy()};
    if (a == A_CY)   return cnt_m;
    return 32'h0;
  endfunction

  always @(negedge clk_DM) begin
    if (cmp_en) begin
      chk("model_tx", {31'b0, tx_DM}, {31'b0, exp_tx()});
      chk("model_busy", {31'b0, tx_busy_DM}, {31'b0, exp_busy()});
      if (rd_known()) chk("model_rd", RD_DM, exp_rd());
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic step();
    @(posedge clk_DM);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] d, input logic we);
    ALU_Out_DM   = a;
    writeData_DM = d;
    MemWrite_DM  = we;
  endtask

  logic [9:0] pat_a5;

  initial begin
    pat_a5 = 10'b11_0100_1010;  // slot 0 first: start, A5 LSB first, stop
    rst_DM = 1'b1;
    drv(A_CY, 32'h0, 1'b0);
    #1 rst_DM = 1'b0;
    #2;
    chk("reset_tx", {31'b0, tx_DM}, 32'h1);
    chk("reset_busy", {31'b0, tx_busy_DM}, 32'h0);
    chk("reset_cycles", RD_DM, 32'h0);
    cmp_en = 1'b1;
    step();
    step();
    rst_DM = 1'b1;
    #1 chk("cycles_at_release", RD_DM, 32'h0);
    step();
    chk("cycles_first_edge", RD_DM, 32'h1);

    // RAM store then readback through an unaligned alias; unmapped read
    drv(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step();
    drv(32'h0000_0013, 32'h0, 1'b0);
    #1 chk("ram_readback", RD_DM, 32'hDEAD_BEEF);
    drv(32'h0000_1000, 32'h0, 1'b0);
    #1 chk("unmapped_read", RD_DM, 32'h0);

    // Frame A5 with an overflowing write 5 cycles in and an overflow clear
    drv(A_ST, 32'h0, 1'b0);
    #1 chk("status_idle", RD_DM, 32'h0);
    drv(A_TX, 32'hA5, 1'b1);
    step();
    for (int j = 0; j < 40; j++) begin
      chk("frame_a5_tx", {31'b0, tx_DM}, {31'b0, pat_a5[j / 4]});
      chk("frame_a5_busy", {31'b0, tx_busy_DM}, 32'h1);
      if (j == 10) chk("status_ovf_busy", RD_DM, 32'h3);
      if (j == 13) chk("status_after_clear", RD_DM, 32'h1);
      if (j == 4)       drv(A_TX, 32'h3C, 1'b1);
      else if (j == 12) drv(A_ST, 32'h2, 1'b1);
      else              drv(A_ST, 32'h0, 1'b0);
      step();
    end
    chk("frame_end_busy", {31'b0, tx_busy_DM}, 32'h0);
    chk("frame_end_tx", {31'b0, tx_DM}, 32'h1);
    chk("frame_end_status", RD_DM, 32'h0);

    // Counter load and wrap
    drv(A_CY, 32'hFFFF_FFFE, 1'b1);
    step();
    drv(A_CY, 32'h0, 1'b0);
    #1 chk("cycles_loaded", RD_DM, 32'hFFFF_FFFE);
    step();
    chk("cycles_max", RD_DM, 32'hFFFF_FFFF);
    step();
    chk("cycles_wrap", RD_DM, 32'h0);

    // Write on the edge busy drops is accepted; one edge earlier is dropped
    drv(A_TX, 32'h0F, 1'b1);
    step();
    drv(A_ST, 32'h0, 1'b0);
    for (int j = 1; j < 40; j++) begin
      step();
      if (j == 39) begin
        chk("b2b_stop_tx", {31'b0, tx_DM}, 32'h1);
        chk("b2b_stop_busy", {31'b0, tx_busy_DM}, 32'h1);
        drv(A_TX, 32'hC3, 1'b1);
      end
    end
    step();
    chk("b2b_start_tx", {31'b0, tx_DM}, 32'h0);
    chk("b2b_start_busy", {31'b0, tx_busy_DM}, 32'h1);
    drv(A_ST, 32'h0, 1'b0);
    #1 chk("b2b_no_ovf", RD_DM, 32'h1);
    for (int j = 1; j < 40; j++) begin
      step();
      if (j == 38) drv(A_TX, 32'h77, 1'b1);
      if (j == 39) begin
        drv(A_ST, 32'h0, 1'b0);
        #1 chk("late_write_ovf", RD_DM, 32'h3);
      end
    end
    step();
    chk("late_frame_done", RD_DM, 32'h2);
    drv(A_ST, 32'h2, 1'b1);
    step();
    drv(A_ST, 32'h0, 1'b0);
    #1 chk("ovf_cleared", RD_DM, 32'h0);

    // Reset in the middle of a frame
    drv(A_TX, 32'h5A, 1'b1);
    step();
    drv(A_CY, 32'h0, 1'b0);
    repeat (10) step();
    #1 rst_DM = 1'b0;
    #1;
    chk("midreset_tx", {31'b0, tx_DM}, 32'h1);
    chk("midreset_busy", {31'b0, tx_busy_DM}, 32'h0);
    step();
    step();
    rst_DM = 1'b1;
    #1 chk("midreset_cycles", RD_DM, 32'h0);
    drv(A_ST, 32'h0, 1'b0);
    #1 chk("midreset_status", RD_DM, 32'h0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)
        drv(A_TX, $urandom, 1'b1);
      else if (r < 6)
        drv(A_ST, $urandom, 1'b1);
      else if (r < 8)
        drv(A_CY, $urandom, 1'b1);
      else if (r < 30)
        drv({24'b0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom)}, $urandom, 1'b1);
      else if (r < 55)
        drv({24'b0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom)}, 32'h0, 1'b0);
      else if (r < 60)
        drv(32'h0001_0000 | $urandom, $urandom, $urandom_range(0, 1) == 1);
      else if (r < 63)
        drv(32'hFFFF_000C, $urandom, $urandom_range(0, 1) == 1);
      else if (r < 80)
        drv(A_ST, 32'h0, 1'b0);
      else
        drv(A_CY, 32'h0, 1'b0);
      step();
    end
    drv(A_ST, 32'h0, 1'b0);
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
